// File: rtl/pipe_stage_skid.sv
// Pipeline stage buffer: valid/ready handshake, optional skid entry, flush to bubble,
// and a saturating bubble-cycle counter.
module pipe_stage_skid #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 128,
  parameter bit SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [15:0]       bubble_cnt
);

  // State encoding equals the number of held entries.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]        state, state_nx;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              in_fire, out_fire;

  assign out_valid = (state != ST_EMPTY);
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;
  assign occupancy = state;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  generate
    if (SKID) begin : g_skid_rdy
      logic rdy_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) rdy_q <= 1'b1;
        else       rdy_q <= (state_nx != ST_TWO);
      end
      assign in_ready = rdy_q;
    end else begin : g_comb_rdy
      assign in_ready = !out_valid | out_ready;
    end
  endgenerate

  always_comb begin
    state_nx = state;
    if (flush) state_nx = ST_EMPTY;
    else begin
      case (state)
        ST_EMPTY: if (in_fire) state_nx = ST_ONE;
        ST_ONE: begin
          if (out_fire && !in_fire)            state_nx = ST_EMPTY;
          else if (!out_fire && in_fire && SKID) state_nx = ST_TWO;
        end
        ST_TWO:   if (out_fire) state_nx = ST_ONE;
        default:  state_nx = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_EMPTY;
    else       state <= state_nx;
  end

  // out_data keeps its last value on drain; only ctrl is forced to NOP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (flush) begin
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
          end else if (out_fire) begin
            main_ctrl <= '0;
          end else if (in_fire && SKID) begin
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
            skid_ctrl <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  bubble_cnt <= '0;
    else if (!out_valid && bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: one SKID=1 and one SKID=0 instance.
module tb_pipe_stage_skid;

  logic         clk = 1'b0;
  logic         reset;
  // SKID=1 instance
  logic         flush, in_valid, in_ready, out_valid, out_ready;
  logic [7:0]   in_ctrl, out_ctrl;
  logic [127:0] in_data, out_data;
  logic [1:0]   occupancy;
  logic [15:0]  bubble_cnt;
  // SKID=0 instance
  logic         flush0, in_valid0, in_ready0, out_valid0, out_ready0;
  logic [7:0]   in_ctrl0, out_ctrl0;
  logic [127:0] in_data0, out_data0;
  logic [1:0]   occupancy0;
  logic [15:0]  bubble_cnt0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.CTRL_W(8), .DATA_W(128), .SKID(1'b1)) u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_skid #(.CTRL_W(8), .DATA_W(128), .SKID(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .flush(flush0),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_ctrl(in_ctrl0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_ctrl(out_ctrl0), .out_data(out_data0),
    .occupancy(occupancy0), .bubble_cnt(bubble_cnt0)
  );

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [127:0] dat(input logic [7:0] c);
    return {16{c}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] c);
    in_valid = 1'b1;
    in_ctrl  = c;
    in_data  = dat(c);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    flush0 = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b0; in_ctrl0 = '0; in_data0 = '0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_bubble", bubble_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_in_ready0", in_ready0, 1);

    // Streaming, SKID=1
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      push(8'(i));
      step();
      chk("stream_valid", out_valid, 1);
      chk("stream_ctrl", out_ctrl, 8'(i));
      chk("stream_data", out_data, dat(8'(i)));
      chk("stream_occ", occupancy, 1);
      chk("stream_in_ready", in_ready, 1);
    end
    chk("stream_bubble", bubble_cnt, 1);
    in_valid = 1'b0;
    step();
    chk("drain_valid", out_valid, 0);
    chk("drain_ctrl", out_ctrl, 0);
    chk("drain_data_hold", out_data, dat(8'h05));

    // Stall and skid, SKID=1
    out_ready = 1'b0;
    push(8'hA1);
    step();
    chk("skid_a_ctrl", out_ctrl, 8'hA1);
    chk("skid_a_rdy", in_ready, 1);
    push(8'hB2);
    step();
    chk("skid_occ2", occupancy, 2);
    chk("skid_rdy0", in_ready, 0);
    chk("skid_a_hold", out_ctrl, 8'hA1);
    in_valid = 1'b0;
    step();
    chk("skid_a_hold2", out_ctrl, 8'hA1);
    chk("skid_a_valid", out_valid, 1);
    out_ready = 1'b1;
    step();
    chk("skid_b_ctrl", out_ctrl, 8'hB2);
    chk("skid_b_data", out_data, dat(8'hB2));
    chk("skid_b_occ", occupancy, 1);
    chk("skid_rdy1", in_ready, 1);
    step();
    chk("skid_empty", out_valid, 0);

    // Flush while in TWO, with C offered
    out_ready = 1'b0;
    push(8'h11); step();
    push(8'h22); step();
    chk("fl_occ2", occupancy, 2);
    push(8'h33);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", out_valid, 0);
    chk("fl_ctrl", out_ctrl, 0);
    chk("fl_data", out_data, 0);
    chk("fl_occ", occupancy, 0);
    chk("fl_rdy", in_ready, 1);
    out_ready = 1'b1;
    step(); step();
    chk("fl_no_c_valid", out_valid, 0);
    chk("fl_no_c_ctrl", out_ctrl, 0);

    // SKID=0 stall: combinational in_ready
    out_ready0 = 1'b0;
    in_valid0 = 1'b1; in_ctrl0 = 8'h44; in_data0 = dat(8'h44);
    step();
    chk("s0_x_ctrl", out_ctrl0, 8'h44);
    chk("s0_rdy_stall", in_ready0, 0);
    chk("s0_occ", occupancy0, 1);
    in_ctrl0 = 8'h55; in_data0 = dat(8'h55);
    step();
    chk("s0_x_hold", out_ctrl0, 8'h44);
    out_ready0 = 1'b1;
    #1;
    chk("s0_rdy_same_cycle", in_ready0, 1);
    step();
    chk("s0_y_ctrl", out_ctrl0, 8'h55);
    chk("s0_y_data", out_data0, dat(8'h55));
    chk("s0_occ_max", occupancy0, 1);
    in_valid0 = 1'b0;
    step();
    chk("s0_empty", out_valid0, 0);

    // Bubble counter saturation
    repeat (66000) step();
    chk("sat_ffff", bubble_cnt, 16'hFFFF);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("sat_after_flush", bubble_cnt, 16'hFFFF);

    // Async reset mid-cycle while in TWO
    out_ready = 1'b0;
    push(8'h66); step();
    push(8'h77); step();
    in_valid = 1'b0;
    chk("ar_occ2", occupancy, 2);
    #3;
    reset = 1'b1;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_ctrl", out_ctrl, 0);
    chk("ar_data", out_data, 0);
    chk("ar_occ", occupancy, 0);
    chk("ar_bubble", bubble_cnt, 0);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    push(8'hAA);
    step();
    in_valid = 1'b0;
    chk("ar_aa_ctrl", out_ctrl, 8'hAA);
    chk("ar_aa_valid", out_valid, 1);
    step();
    chk("ar_aa_gone", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
